// File: rtl/pdpw_pkg.sv
// ============================================================================
// pdpw_pkg : shared lane geometry and helpers for the PDPW packer/unpacker
// Rev 1.0
// ============================================================================
`default_nettype none

package pdpw_pkg;
    localparam int LANES  = 4;
    localparam int LANE_W = 9;
    localparam int BYTE_W = 8;
    localparam int WORD_W = LANES * LANE_W;
    localparam int ADDR_W = 9;

    typedef logic [LANES-1:0] lane_mask_t;

    function automatic logic lane_parity(input logic [BYTE_W-1:0] data);
        return ^data;
    endfunction
endpackage

`default_nettype wire

// File: rtl/pdpw_lane_assembler.sv
// ============================================================================
// pdpw_lane_assembler : collects bytes into four 9-bit lanes, flags commits
// Optional: PDPW_PACK_PARITY_EN puts even parity in lane bit 8
// Rev 1.0
// ============================================================================
`default_nettype none

module pdpw_lane_assembler
    import pdpw_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BYTE_W-1:0]    data,
    input  logic                 accept,
    input  logic                 flush,
    output logic                 commit,
    output logic [WORD_W-1:0]    word,
    output lane_mask_t           mask
);
    logic [1:0]                       r_li;
    lane_mask_t                       r_mask;
    logic [LANES-1:0][BYTE_W-1:0]     r_lane;

    lane_mask_t                       w_mask_next;
    logic [LANES-1:0][BYTE_W-1:0]     w_lane_next;
    logic [LANES-1:0]                 w_par;

    // The byte accepted this cycle is already part of the outgoing word.
    always_comb begin
        w_mask_next = r_mask;
        w_lane_next = r_lane;
        if (accept) begin
            w_mask_next[r_li] = 1'b1;
            w_lane_next[r_li] = data;
        end
    end

    assign commit = (accept && (r_li == 2'(LANES - 1))) ||
                    (flush && (w_mask_next != '0));
    assign mask   = w_mask_next;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
`ifdef PDPW_PACK_PARITY_EN
        assign w_par[g] = lane_parity(w_lane_next[g]);
`else
        assign w_par[g] = 1'b0;
`endif
        assign word[g*LANE_W +: LANE_W] = w_mask_next[g] ? {w_par[g], w_lane_next[g]}
                                                         : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_li   <= '0;
            r_mask <= '0;
            r_lane <= '0;
        end else if (commit) begin
            r_li   <= '0;
            r_mask <= '0;
            r_lane <= w_lane_next;
        end else if (accept) begin
            r_li   <= r_li + 2'd1;
            r_mask <= w_mask_next;
            r_lane <= w_lane_next;
        end
    end
endmodule

`default_nettype wire

// File: rtl/pdpw_write_packer.sv
// ============================================================================
// pdpw_write_packer : byte-stream write front-end for the 36-bit PDPW EBR port
// Optional: PDPW_PACK_PARITY_EN enables per-lane even parity in bit 8
// Rev 1.0
// ============================================================================
`default_nettype none

module pdpw_write_packer
    import pdpw_pkg::*;
#(
    parameter int DEPTH     = 512,
    parameter int BASE_ADDR = 0
)(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BYTE_W-1:0]    DIN,
    input  logic                 DIN_VLD,
    output logic                 DIN_RDY,
    input  logic                 FLUSH,
    input  logic                 FREE,
    output logic [WORD_W-1:0]    DI,
    output logic [ADDR_W-1:0]    ADW,
    output logic [LANES-1:0]     BE,
    output logic                 CEW,
    output logic [9:0]           OCC,
    output logic                 UNDERFLOW
);
    localparam logic [9:0]        c_DEPTH = 10'(DEPTH);
    localparam logic [ADDR_W-1:0] c_BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(BASE_ADDR + DEPTH - 1);

    logic                 r_rdy;
    logic                 r_flush_pend;
    logic [9:0]           r_occ;
    logic [ADDR_W-1:0]    r_wptr;
    logic                 r_underflow;
    logic [WORD_W-1:0]    r_di;
    logic [ADDR_W-1:0]    r_adw;
    lane_mask_t           r_be;
    logic                 r_cew;

    logic                 w_accept;
    logic                 w_free_eff;
    logic                 w_room;
    logic                 w_flush_srv;
    logic                 w_commit;
    logic [WORD_W-1:0]    w_word;
    lane_mask_t           w_mask;
    logic [9:0]           w_occ_next;

    assign w_accept    = DIN_VLD & r_rdy;
    assign w_free_eff  = FREE & (r_occ != '0);
    // A free in the same cycle opens a slot for a pending flush.
    assign w_room      = (r_occ != c_DEPTH) | FREE;
    assign w_flush_srv = (r_flush_pend | FLUSH) & w_room;

    pdpw_lane_assembler u_asm (
        .clk    (CLK),
        .rst    (RST),
        .data   (DIN),
        .accept (w_accept),
        .flush  (w_flush_srv),
        .commit (w_commit),
        .word   (w_word),
        .mask   (w_mask)
    );

    always_comb begin
        w_occ_next = r_occ;
        if (w_commit && !w_free_eff) begin
            w_occ_next = r_occ + 10'd1;
        end else if (!w_commit && w_free_eff) begin
            w_occ_next = r_occ - 10'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rdy        <= 1'b0;
            r_flush_pend <= 1'b0;
            r_occ        <= '0;
            r_wptr       <= c_BASE;
            r_underflow  <= 1'b0;
            r_di         <= '0;
            r_adw        <= c_BASE;
            r_be         <= '0;
            r_cew        <= 1'b0;
        end else begin
            r_rdy        <= (w_occ_next != c_DEPTH);
            r_occ        <= w_occ_next;
            r_cew        <= w_commit;
            r_flush_pend <= w_flush_srv ? 1'b0 : (r_flush_pend | FLUSH);
            if (FREE && (r_occ == '0)) begin
                r_underflow <= 1'b1;
            end
            if (w_commit) begin
                r_di   <= w_word;
                r_be   <= w_mask;
                r_adw  <= r_wptr;
                r_wptr <= (r_wptr == c_LAST) ? c_BASE : r_wptr + 1'b1;
            end
        end
    end

    assign DIN_RDY   = r_rdy;
    assign DI        = r_di;
    assign ADW       = r_adw;
    assign BE        = r_be;
    assign CEW       = r_cew;
    assign OCC       = r_occ;
    assign UNDERFLOW = r_underflow;
endmodule

`default_nettype wire

// File: tb/tb_pdpw_write_packer.sv
// ============================================================================
// tb_pdpw_write_packer : scoreboard bench for pdpw_write_packer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pdpw_write_packer;
    localparam int DEPTH = 4;
    localparam int BASE  = 5;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  DIN = '0;
    logic        DIN_VLD = 1'b0;
    logic        FLUSH = 1'b0;
    logic        FREE = 1'b0;
    logic        DIN_RDY;
    logic [35:0] DI;
    logic [8:0]  ADW;
    logic [3:0]  BE;
    logic        CEW;
    logic [9:0]  OCC;
    logic        UNDERFLOW;

    always #5 CLK = ~CLK;

    pdpw_write_packer #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .CLK(CLK), .RST(RST), .DIN(DIN), .DIN_VLD(DIN_VLD), .DIN_RDY(DIN_RDY),
        .FLUSH(FLUSH), .FREE(FREE), .DI(DI), .ADW(ADW), .BE(BE), .CEW(CEW),
        .OCC(OCC), .UNDERFLOW(UNDERFLOW)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Expected committed words: {DI, BE, ADW}
    logic [48:0] exp_q[$];

    // Reference model state: bytes of the open word, words held by reader, words written.
    logic [7:0]  m_bytes[$];
    int          m_occ = 0;
    int          m_wcount = 0;
    bit          m_pend = 0;
    bit          m_rdy = 0;
    bit          m_unf = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic lane_par(input logic [7:0] b);
`ifdef PDPW_PACK_PARITY_EN
        return ^b;
`else
        return 1'b0 & b[0];
`endif
    endfunction

    task automatic model_step(input bit vld, input logic [7:0] d, input bit fl,
                              input bit fr, input bit rs);
        bit          acc, room, req, srv, commit, fe;
        logic [35:0] w;
        int          n;
        if (rs) begin
            m_bytes.delete();
            m_occ = 0; m_wcount = 0; m_pend = 0; m_rdy = 0; m_unf = 0;
            return;
        end
        acc  = vld && m_rdy;
        room = (m_occ < DEPTH) || fr;
        req  = m_pend || fl;
        srv  = req && room;
        if (acc) m_bytes.push_back(d);
        n = m_bytes.size();
        commit = (n == 4) || (srv && n > 0);
        if (commit) begin
            w = '0;
            for (int i = 0; i < n; i++) w[9*i +: 9] = {lane_par(m_bytes[i]), m_bytes[i]};
            exp_q.push_back({w, 4'((1 << n) - 1), 9'(BASE + (m_wcount % DEPTH))});
            m_bytes.delete();
            m_wcount++;
        end
        fe = fr && (m_occ > 0);
        if (fr && m_occ == 0) m_unf = 1;
        m_occ  = m_occ + (commit ? 1 : 0) - (fe ? 1 : 0);
        m_pend = srv ? 1'b0 : req;
        m_rdy  = (m_occ != DEPTH);
    endtask

    task automatic cycle(input bit vld, input logic [7:0] d, input bit fl,
                         input bit fr, input bit rs);
        DIN_VLD = vld; DIN = d; FLUSH = fl; FREE = fr; RST = rs;
        model_step(vld, d, fl, fr, rs);
        @(posedge CLK);
        #1;
        check("status{rdy,occ,unf}", 64'({DIN_RDY, OCC, UNDERFLOW}),
              64'({m_rdy, 10'(m_occ), m_unf}));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 8'h00, 0, 0, 0);
    endtask

    // Monitor: every write strobe must match the oldest predicted word.
    always @(negedge CLK) begin : mon
        logic [48:0] e;
        if (CEW !== 1'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL word_unexpected: got CEW=%b DI=%h BE=%h ADW=%h expected no write",
                         CEW, DI, BE, ADW);
            end else begin
                e = exp_q.pop_front();
                check("word{DI,BE,ADW}", 64'({DI, BE, ADW}), 64'(e));
            end
        end
    end

    initial begin
        repeat (3) cycle(0, 8'h00, 0, 0, 1);
        check("reset{DI,BE,ADW,CEW}", 64'({DI, BE, ADW, CEW}), 64'({36'h0, 4'h0, 9'(BASE), 1'b0}));

        // Full word on consecutive cycles
        cycle(1, 8'h11, 0, 0, 0);
        cycle(1, 8'h22, 0, 0, 0);
        cycle(1, 8'h33, 0, 0, 0);
        cycle(1, 8'h44, 0, 0, 0);
        idle(2);

        // Partial word committed by flush
        cycle(1, 8'h01, 0, 0, 0);
        cycle(1, 8'h03, 0, 0, 0);
        cycle(0, 8'h00, 1, 0, 0);
        idle(2);

        // Drain, then free at zero occupancy
        cycle(0, 8'h00, 0, 1, 0);
        cycle(0, 8'h00, 0, 1, 0);
        cycle(0, 8'h00, 0, 1, 0);
        idle(1);

        // Reset in the middle of a word
        cycle(1, 8'hA1, 0, 0, 0);
        cycle(1, 8'hA2, 0, 0, 0);
        cycle(1, 8'hA3, 0, 0, 0);
        cycle(0, 8'h00, 0, 0, 1);
        idle(1);
        for (int i = 0; i < 4; i++) cycle(1, 8'(8'hB0 + i), 0, 0, 0);
        idle(1);
        cycle(0, 8'h00, 0, 1, 0);

        // Stream into a full window, then one free and wrap
        for (int i = 0; i < 20; i++) cycle(1, 8'(i + 1), 0, 0, 0);
        cycle(1, 8'hC0, 0, 1, 0);
        for (int i = 0; i < 6; i++) cycle(1, 8'(8'hC1 + i), 0, 0, 0);

        // Flush while full is held until a slot frees
        cycle(0, 8'h00, 1, 0, 0);
        idle(2);
        cycle(0, 8'h00, 0, 1, 0);
        idle(2);
        for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 0, 1, 0);
        idle(2);

        // Randomised phases: filling-biased then draining-biased
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 400; i++) begin
                cycle($urandom_range(0, 99) < 75,
                      8'($urandom_range(0, 255)),
                      $urandom_range(0, 99) < 8,
                      $urandom_range(0, 99) < ((p % 2 == 0) ? 12 : 55),
                      $urandom_range(0, 399) == 0);
            end
        end

        idle(4);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
